// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sseg_pkg
// Purpose  : Shared constants for the seven-segment capture path.
// Revision : 1.0
// ============================================================================
package sseg_pkg;

   localparam int c_N_DIGITS = 8;

   // Digit word layout {en, num[3:0], dp}
   localparam int c_EN      = 5;
   localparam int c_NUM_MSB = 4;
   localparam int c_NUM_LSB = 1;
   localparam int c_DP      = 0;

   // Active-low pin value with every segment dark
   localparam logic [6:0] c_SEG_BLANK_N = 7'h7F;

   // Active-high gfedcba patterns for hex digits 0..F
   localparam logic [6:0] c_SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef logic [5:0] digit_word_t;

   function automatic digit_word_t make_word(input logic en, input logic [3:0] num,
                                             input logic dp);
      return {en, num, dp};
   endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module   : sseg_pattern_decode
// Purpose  : Maps active-low segment pins to {legal, blank, hex}.
// Revision : 1.0
// ============================================================================
module sseg_pattern_decode
   import sseg_pkg::*;
(
   input  logic [6:0] i_seg_n,
   output logic       o_legal,
   output logic       o_blank,
   output logic [3:0] o_hex
);

   logic [6:0] w_seg;

   assign w_seg   = ~i_seg_n;
   assign o_blank = (i_seg_n == c_SEG_BLANK_N);

   always_comb begin
      o_legal = 1'b0;
      o_hex   = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (w_seg == c_SEG_TABLE[i]) begin
            o_legal = 1'b1;
            o_hex   = 4'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sseg_capture.sv
`default_nettype none
// ============================================================================
// Module   : sseg_capture
// Purpose  : Rebuilds per-digit words from scanned seven-segment pins.
// Revision : 1.0
// ============================================================================
module sseg_capture
   import sseg_pkg::*;
#(
   parameter int STABLE_CYCLES = 16
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            AN,
   input  logic [6:0]            bcd,
   input  logic                  DP,
   output logic [5:0]            O0,
   output logic [5:0]            O1,
   output logic [5:0]            O2,
   output logic [5:0]            O3,
   output logic [5:0]            O4,
   output logic [5:0]            O5,
   output logic [5:0]            O6,
   output logic [5:0]            O7,
   output logic [c_N_DIGITS-1:0] valid,
   output logic                  frame_done,
   output logic                  decode_err
);

   localparam int              c_CW      = $clog2(STABLE_CYCLES + 1);
   localparam int              c_IW      = $clog2(c_N_DIGITS);
   localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(STABLE_CYCLES);
   localparam logic [c_CW-1:0] c_CNT_PRE = c_CW'(STABLE_CYCLES - 1);

   logic [15:0]           r_sample;
   logic [15:0]           r_sample_d;
   logic [c_CW-1:0]       r_cnt;
   logic                  r_accept;
   logic [15:0]           r_acc;
   digit_word_t           r_word [c_N_DIGITS];
   logic [c_N_DIGITS-1:0] r_valid;
   logic [c_N_DIGITS-1:0] r_seen;
   logic [c_IW-1:0]       r_last;
   logic                  r_have_last;
   logic                  r_frame_done;
   logic                  r_decode_err;

   logic [7:0]            w_an_n;
   logic                  w_single;
   logic                  w_multi;
   logic [c_IW-1:0]       w_idx;
   logic                  w_legal;
   logic                  w_blank;
   logic [3:0]            w_hex;
   logic                  w_take;
   logic                  w_bad;
   logic                  w_wrap;
   digit_word_t           w_word;

   // Stability window: accept fires once, on the clock cnt reaches the limit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sample   <= '0;
         r_sample_d <= '0;
         r_cnt      <= '0;
         r_accept   <= 1'b0;
         r_acc      <= '0;
      end else begin
         r_sample   <= {AN, bcd, DP};
         r_sample_d <= r_sample;
         r_accept   <= 1'b0;
         if (r_sample != r_sample_d) begin
            r_cnt <= '0;
         end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + c_CW'(1);
            if (r_cnt == c_CNT_PRE) begin
               r_accept <= 1'b1;
               r_acc    <= r_sample;
            end
         end
      end
   end

   sseg_pattern_decode u_decode (
      .i_seg_n (r_acc[7:1]),
      .o_legal (w_legal),
      .o_blank (w_blank),
      .o_hex   (w_hex)
   );

   assign w_an_n   = ~r_acc[15:8];
   assign w_single = (w_an_n != 8'h00) && ((w_an_n & (w_an_n - 8'd1)) == 8'h00);
   assign w_multi  = (w_an_n != 8'h00) && !w_single;

   always_comb begin
      w_idx = '0;
      for (int i = 0; i < c_N_DIGITS; i++) begin
         if (w_an_n[i]) w_idx = c_IW'(i);
      end
   end

   // Blank segments decode as hex 0 with legal=0, giving en=0 directly
   assign w_word = make_word(w_legal, w_hex, ~r_acc[0]);
   assign w_take = r_accept && w_single && (w_legal || w_blank);
   assign w_bad  = r_accept && (w_multi || (w_single && !(w_legal || w_blank)));
   assign w_wrap = w_take && r_have_last && (w_idx <= r_last);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int j = 0; j < c_N_DIGITS; j++) r_word[j] <= '0;
         r_valid      <= '0;
         r_seen       <= '0;
         r_last       <= '0;
         r_have_last  <= 1'b0;
         r_frame_done <= 1'b0;
         r_decode_err <= 1'b0;
      end else begin
         r_frame_done <= w_wrap;
         r_decode_err <= w_bad;
         if (w_take) begin
            if (w_wrap) begin
               r_valid <= r_seen;
               for (int j = 0; j < c_N_DIGITS; j++) begin
                  if (!r_seen[j]) r_word[j][c_EN] <= 1'b0;
               end
               r_seen <= w_an_n;
            end else begin
               r_seen <= r_seen | w_an_n;
            end
            // Written after the stale-en clear so the current digit keeps en
            r_word[w_idx] <= w_word;
            r_last        <= w_idx;
            r_have_last   <= 1'b1;
         end
      end
   end

   assign O0         = r_word[0];
   assign O1         = r_word[1];
   assign O2         = r_word[2];
   assign O3         = r_word[3];
   assign O4         = r_word[4];
   assign O5         = r_word[5];
   assign O6         = r_word[6];
   assign O7         = r_word[7];
   assign valid      = r_valid;
   assign frame_done = r_frame_done;
   assign decode_err = r_decode_err;

endmodule
`default_nettype wire
